id_ex: RTL and testbench
========================

Name: id_ex

Overview:
- ID/EX pipeline register of the RV32I 5-stage pipeline.
- Sits between the Decode and Execute stages.
- Captures the decoded fields, register-file read values and control bits each clock when enabled, and holds them otherwise (stall).
- All outputs come straight from flops; there is no combinational path from any input to any output.

Parameters:
- XLEN, 32, width of imm, val_A and val_B.
- REG_ADDR_W, 5, width of rs1, rs2 and rd.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- enable  input  1  load strobe; 1 = capture inputs, 0 = hold (stall)
- ula_in  input  1  ALU operation control bit
- mux_res_ula_in  input  1  ALU-result mux select
- mem_rd_in  input  1  data-memory read enable
- mem_wr_in  input  1  data-memory write enable
- reg_wr_in  input  1  register-file write enable
- mux_reg_wr_in  input  1  write-back source mux select
- imm_in  input  XLEN  sign-extended immediate
- rs1_in  input  REG_ADDR_W  source register 1 index
- rs2_in  input  REG_ADDR_W  source register 2 index
- rd_in  input  REG_ADDR_W  destination register index
- funct7_in  input  7  instruction funct7
- funct3_in  input  3  instruction funct3
- val_A_in  input  XLEN  rs1 read value
- val_B_in  input  XLEN  rs2 read value
- Outputs ula_out, mux_res_ula_out, mem_rd_out, mem_wr_out, reg_wr_out, mux_reg_wr_out, imm_out, rs1_out, rs2_out, rd_out, funct7_out, funct3_out, val_A_out, val_B_out: each has the same width as its _in counterpart and is the registered copy of it.
- flush  input  1  bubble insert; present only when ID_EX_FLUSH_EN is defined.

Behaviour:
- Reset (rst == 0) is asynchronous.
  - All 14 outputs go to 0 immediately, without waiting for a clock edge.
  - They stay at 0 while rst is low, regardless of clk, enable or data inputs.
  - Reset asserted mid-operation discards the held contents.
- On each rising clk edge with rst == 1:
  - enable == 1: every output takes the value of its _in counterpart. Latency is 1 cycle.
  - enable == 0: every output holds its previous value. Input changes are ignored.
- Reset release:
  - The first capture happens at the first rising edge after rst returns to 1 with enable == 1.
  - There is no synchronous reset path.
- All fields load together. No field is ever partially updated.
- Pure storage: no arithmetic, no width conversion. Bits pass through unchanged.

Optional Feature:
- Macro: ID_EX_FLUSH_EN.
- Defined:
  - Adds the flush input port.
  - On a rising edge with rst == 1 and flush == 1, all outputs are synchronously cleared to 0, producing a NOP bubble with reg_wr_out = 0, mem_wr_out = 0 and rd_out = 0.
  - flush has priority over enable. Clearing happens even when enable == 0.
  - Asynchronous reset has priority over flush.
- Undefined:
  - The port is absent.
  - Behaviour is exactly as described above with enable and rst only.

Test Plan:
1. Reset: rst = 0 with all inputs nonzero -> all outputs 0 at once, with no clock edge required.
2. Load: rst = 1, enable = 1, imm_in = AAAABBBB, rs1/rs2/rd = 10/11/12, funct7 = 1F, funct3 = 3, val_A = 11111111, val_B = 22222222, ula = 1, mux_res_ula = 0, mem_rd = 1, mem_wr = 0, reg_wr = 1, mux_reg_wr = 1 -> after the next rising edge the outputs equal exactly these values.
3. Stall: following 2, enable = 0, imm_in = DEADBEEF, rs1/rs2/rd = 1/2/3, clock 2 edges -> outputs still AAAABBBB/10/11/12 with all the other fields from 2 unchanged.
4. Mid-operation reset: with the outputs loaded, drive rst = 0 between clock edges -> all outputs 0 before the next edge. Release rst with enable = 0 -> outputs stay 0.
5. Back-to-back load: enable = 1, rd_in = 5 then 6 on consecutive edges -> rd_out = 5 then 6, one-cycle latency each.
6. (ID_EX_FLUSH_EN) Loaded state from 2, flush = 1, enable = 0, one edge -> all outputs 0. Then flush = 0, enable = 1 -> normal loading resumes.

Source files
------------

// File: rtl/id_ex.sv
// ID/EX pipeline register for the RV32I 5-stage pipeline: holds decoded fields and operands for Execute.
// Optional ID_EX_FLUSH_EN adds a synchronous flush input that inserts a NOP bubble.
module id_ex #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
`ifdef ID_EX_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  ula_in,
    input  logic                  mux_res_ula_in,
    input  logic                  mem_rd_in,
    input  logic                  mem_wr_in,
    input  logic                  reg_wr_in,
    input  logic                  mux_reg_wr_in,
    input  logic [XLEN-1:0]       imm_in,
    input  logic [REG_ADDR_W-1:0] rs1_in,
    input  logic [REG_ADDR_W-1:0] rs2_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [6:0]            funct7_in,
    input  logic [2:0]            funct3_in,
    input  logic [XLEN-1:0]       val_A_in,
    input  logic [XLEN-1:0]       val_B_in,
    output logic                  ula_out,
    output logic                  mux_res_ula_out,
    output logic                  mem_rd_out,
    output logic                  mem_wr_out,
    output logic                  reg_wr_out,
    output logic                  mux_reg_wr_out,
    output logic [XLEN-1:0]       imm_out,
    output logic [REG_ADDR_W-1:0] rs1_out,
    output logic [REG_ADDR_W-1:0] rs2_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [6:0]            funct7_out,
    output logic [2:0]            funct3_out,
    output logic [XLEN-1:0]       val_A_out,
    output logic [XLEN-1:0]       val_B_out
);

    localparam int PW = 6 + 3 * XLEN + 3 * REG_ADDR_W + 10;

    logic [PW-1:0] in_s;
    logic [PW-1:0] pipe_d;
    logic [PW-1:0] pipe_q;

    // All fields travel as one word so they can only ever load together
    assign in_s = {ula_in, mux_res_ula_in, mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in,
                   imm_in, rs1_in, rs2_in, rd_in, funct7_in, funct3_in, val_A_in, val_B_in};

    // Next-state selection: flush bubble, capture, or hold
    always_comb begin
        pipe_d = pipe_q;
`ifdef ID_EX_FLUSH_EN
        if (flush) begin
            pipe_d = {PW{1'b0}};
        end else if (enable) begin
            pipe_d = in_s;
        end else begin
            pipe_d = pipe_q;
        end
`else
        if (enable) begin
            pipe_d = in_s;
        end else begin
            pipe_d = pipe_q;
        end
`endif
    end

    // Pipeline storage with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= {PW{1'b0}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign {ula_out, mux_res_ula_out, mem_rd_out, mem_wr_out, reg_wr_out, mux_reg_wr_out,
            imm_out, rs1_out, rs2_out, rd_out, funct7_out, funct3_out,
            val_A_out, val_B_out} = pipe_q;

endmodule

// File: tb/tb_id_ex.sv
// Scoreboard bench for id_ex: driver pushes model-predicted register contents, a monitor
// pops and compares on every falling clock edge.
module tb_id_ex;

    typedef struct packed {
        logic        ula;
        logic        mres;
        logic        mrd;
        logic        mwr;
        logic        rwr;
        logic        mrw;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] va;
        logic [31:0] vb;
    } fields_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    enable;
    logic    flush_s;
    fields_t stim;
    fields_t model;
    fields_t exp_q[$];
    int      n_cmp = 0;
    int      n_err = 0;

    logic        ula_o, mres_o, mrd_o, mwr_o, rwr_o, mrw_o;
    logic [31:0] imm_o, va_o, vb_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [6:0]  f7_o;
    logic [2:0]  f3_o;

    always #5 clk = ~clk;

    id_ex dut (
        .clk(clk), .rst(rst), .enable(enable),
`ifdef ID_EX_FLUSH_EN
        .flush(flush_s),
`endif
        .ula_in(stim.ula), .mux_res_ula_in(stim.mres), .mem_rd_in(stim.mrd),
        .mem_wr_in(stim.mwr), .reg_wr_in(stim.rwr), .mux_reg_wr_in(stim.mrw),
        .imm_in(stim.imm), .rs1_in(stim.rs1), .rs2_in(stim.rs2), .rd_in(stim.rd),
        .funct7_in(stim.f7), .funct3_in(stim.f3), .val_A_in(stim.va), .val_B_in(stim.vb),
        .ula_out(ula_o), .mux_res_ula_out(mres_o), .mem_rd_out(mrd_o),
        .mem_wr_out(mwr_o), .reg_wr_out(rwr_o), .mux_reg_wr_out(mrw_o),
        .imm_out(imm_o), .rs1_out(rs1_o), .rs2_out(rs2_o), .rd_out(rd_o),
        .funct7_out(f7_o), .funct3_out(f3_o), .val_A_out(va_o), .val_B_out(vb_o)
    );

    function automatic fields_t rand_fields();
        fields_t f;
        f.ula  = 1'($urandom_range(0, 1));
        f.mres = 1'($urandom_range(0, 1));
        f.mrd  = 1'($urandom_range(0, 1));
        f.mwr  = 1'($urandom_range(0, 1));
        f.rwr  = 1'($urandom_range(0, 1));
        f.mrw  = 1'($urandom_range(0, 1));
        f.imm  = $urandom;
        f.rs1  = 5'($urandom_range(0, 31));
        f.rs2  = 5'($urandom_range(0, 31));
        f.rd   = 5'($urandom_range(0, 31));
        f.f7   = 7'($urandom_range(0, 127));
        f.f3   = 3'($urandom_range(0, 7));
        f.va   = $urandom;
        f.vb   = $urandom;
        return f;
    endfunction

    // One clocked cycle: apply inputs, let the edge happen, predict the register contents
    task automatic step(input fields_t d, input bit en, input bit fl);
        @(negedge clk);
        #1;
        stim    = d;
        enable  = en;
        flush_s = fl;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        if (fl)      model = '0;
        else if (en) model = d;
        exp_q.push_back(model);
    endtask

    // Cycle that ends with reset asserted between edges; check lands before the next edge
    task automatic reset_step(input fields_t d, input bit en);
        @(negedge clk);
        #1;
        stim    = d;
        enable  = en;
        flush_s = 1'b0;
        @(posedge clk);
        #1;
        if (rst && en) model = d;
        rst = 1'b0;
        #1;
        model = '0;
        exp_q.push_back(model);
    endtask

    // Monitor: compare the registered outputs against the oldest prediction
    initial begin
        fields_t e;
        fields_t act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {ula_o, mres_o, mrd_o, mwr_o, rwr_o, mrw_o, imm_o, rs1_o, rs2_o, rd_o,
                       f7_o, f3_o, va_o, vb_o};
                n_cmp++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL regs @%0t: got %h expected %h", $time, act, e);
                end
            end
        end
    end

    initial begin
        fields_t d;
        fields_t ld;
        bit      fl;
        rst     = 1'b0;
        enable  = 1'b1;
        flush_s = 1'b0;
        stim    = rand_fields();
        stim.rwr = 1'b1;
        stim.imm = 32'hFFFF_FFFF;
        model   = '0;
        exp_q.push_back(model);

        // Directed load pattern
        ld      = '0;
        ld.ula  = 1'b1; ld.mres = 1'b0; ld.mrd = 1'b1; ld.mwr = 1'b0; ld.rwr = 1'b1; ld.mrw = 1'b1;
        ld.imm  = 32'hAAAA_BBBB;
        ld.rs1  = 5'd10; ld.rs2 = 5'd11; ld.rd = 5'd12;
        ld.f7   = 7'h1F; ld.f3 = 3'd3;
        ld.va   = 32'h1111_1111; ld.vb = 32'h2222_2222;
        step(ld, 1'b1, 1'b0);

        // Stall: changed inputs must be ignored
        d = ld;
        d.imm = 32'hDEAD_BEEF; d.rs1 = 5'd1; d.rs2 = 5'd2; d.rd = 5'd3;
        step(d, 1'b0, 1'b0);
        step(d, 1'b0, 1'b0);

        // Mid-operation reset, release with enable low
        reset_step(d, 1'b0);
        step(d, 1'b0, 1'b0);
        step(rand_fields(), 1'b0, 1'b0);

        // Back-to-back loads
        d = rand_fields(); d.rd = 5'd5;
        step(d, 1'b1, 1'b0);
        d = rand_fields(); d.rd = 5'd6;
        step(d, 1'b1, 1'b0);

`ifdef ID_EX_FLUSH_EN
        step(ld, 1'b1, 1'b0);
        step(rand_fields(), 1'b0, 1'b1);
        step(ld, 1'b1, 1'b0);
        step(rand_fields(), 1'b1, 1'b1);
`endif

        // Randomized traffic with occasional resets and flushes
        for (int i = 0; i < 400; i++) begin
            d = rand_fields();
`ifdef ID_EX_FLUSH_EN
            fl = ($urandom_range(0, 15) == 0);
`else
            fl = 1'b0;
`endif
            if ($urandom_range(0, 31) == 0) reset_step(d, 1'($urandom_range(0, 1)));
            else                            step(d, 1'($urandom_range(0, 1)), fl);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
